// File: rtl/decode_issue_queue_pkg.sv
// Purpose : shared types and field layout of the decoded-instruction bundle
//           passed from the decode mux stage to register-read/issue.
// Contents: format codes, field widths, bit offsets (LSB position) of every
//           field, the packed bundle struct and a small field-extract helper.
package decode_issue_queue_pkg;

  localparam int OPCODE_W  = 6;
  localparam int REG_W     = 5;
  localparam int XOPCODE_W = 10;
  localparam int ADDR_W    = 64;
  localparam int IMM_W     = 64;
  localparam int FORMAT_W  = 5;

  typedef enum logic [FORMAT_W-1:0] {
    FMT_INVALID = 5'd0,
    FMT_A       = 5'd1,
    FMT_D       = 5'd3,
    FMT_Z23     = 5'd25
  } format_e;

  // Field LSB positions; the bundle is laid out MSB-first starting with imm.
  localparam int FORMAT_LSB       = 0;
  localparam int XOP_EN_LSB       = FORMAT_LSB + FORMAT_W;    // 5
  localparam int XOPCODE_LSB      = XOP_EN_LSB + 1;           // 6
  localparam int OPCODE_LSB       = XOPCODE_LSB + XOPCODE_W;  // 16
  localparam int ADDR_LSB         = OPCODE_LSB + OPCODE_W;    // 22
  localparam int REG2_VOZ_LSB     = ADDR_LSB + ADDR_W;        // 86
  localparam int BIT2_EN_LSB      = REG2_VOZ_LSB + 1;         // 87
  localparam int BIT1_EN_LSB      = BIT2_EN_LSB + 1;          // 88
  localparam int BIT2_LSB         = BIT1_EN_LSB + 1;          // 89
  localparam int BIT1_LSB         = BIT2_LSB + 1;             // 90
  localparam int REG3_IS_IMM_LSB  = BIT1_LSB + 1;             // 91
  localparam int REG3_EN_LSB      = REG3_IS_IMM_LSB + 1;      // 92
  localparam int REG2_EN_LSB      = REG3_EN_LSB + 1;          // 93
  localparam int REG1_EN_LSB      = REG2_EN_LSB + 1;          // 94
  localparam int REG3_LSB         = REG1_EN_LSB + 1;          // 95
  localparam int REG2_LSB         = REG3_LSB + REG_W;         // 100
  localparam int REG1_LSB         = REG2_LSB + REG_W;         // 105
  localparam int IMM_EN_LSB       = REG1_LSB + REG_W;         // 110
  localparam int IMM_LSB          = IMM_EN_LSB + 1;           // 111

  localparam int PAYLOAD_WIDTH = IMM_LSB + IMM_W;             // 175

  typedef struct packed {
    logic [IMM_W-1:0]     imm;
    logic                 imm_en;
    logic [REG_W-1:0]     reg1;
    logic [REG_W-1:0]     reg2;
    logic [REG_W-1:0]     reg3;
    logic                 reg1_en;
    logic                 reg2_en;
    logic                 reg3_en;
    logic                 reg3_is_imm;
    logic                 bit1;
    logic                 bit2;
    logic                 bit1_en;
    logic                 bit2_en;
    logic                 reg2_val_or_zero;
    logic [ADDR_W-1:0]    address;
    logic [OPCODE_W-1:0]  opcode;
    logic [XOPCODE_W-1:0] xopcode;
    logic                 xopcode_en;
    logic [FORMAT_W-1:0]  format;
  } decoded_instr_t;

  function automatic logic [ADDR_W-1:0] instr_address(input logic [PAYLOAD_WIDTH-1:0] p);
    return p[ADDR_LSB +: ADDR_W];
  endfunction

endpackage

// File: rtl/decode_issue_queue_sync_fifo_ptr.sv
// Purpose : generic FIFO pointer/occupancy tracker with wrap-bit pointers.
// Latency : pointers advance at the clock edge of an accepted push/pop.
// Backpressure: push refused when full; flush moves rd onto wr and wins
//               over push/pop in the same cycle.
// Ports   : clk, rst (async high), flush, push, pop -> wr_idx/rd_idx (array
//           indices), full, empty, count, push_ok (write strobe for storage).
module sync_fifo_ptr #(
  parameter int PtrWidth = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  output logic [PtrWidth-1:0] wr_idx,
  output logic [PtrWidth-1:0] rd_idx,
  output logic                full,
  output logic                empty,
  output logic [PtrWidth:0]   count,
  output logic                push_ok
);

  localparam logic [PtrWidth:0] PtrOne = {{PtrWidth{1'b0}}, 1'b1};

  logic [PtrWidth:0] wr_ptr;
  logic [PtrWidth:0] rd_ptr;
  logic              pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  // Same slot but opposite wrap bit: writer is a full lap ahead.
  assign full    = (wr_ptr[PtrWidth-1:0] == rd_ptr[PtrWidth-1:0]) &&
                   (wr_ptr[PtrWidth] != rd_ptr[PtrWidth]);
  assign count   = wr_ptr - rd_ptr;
  assign wr_idx  = wr_ptr[PtrWidth-1:0];
  assign rd_idx  = rd_ptr[PtrWidth-1:0];
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PtrOne;
      if (pop_ok)  rd_ptr <= rd_ptr + PtrOne;
    end
  end

endmodule

// File: rtl/decode_issue_queue.sv
// Purpose : in-order queue of decoded instructions between decode mux and
//           register-read/issue; absorbs issue-side stalls.
// Latency : entry written at edge N is visible on instr_o/valid_o after N;
//           no bypass from instr_i.
// Backpressure: stall_o = full; enable_i while full is dropped and sets the
//           sticky overflow_o. flush_i empties the queue and clears overflow.
// Ports   : clock_i, reset_i, flush_i, enable_i/instr_i (in), stall_o,
//           valid_o/instr_o/ready_i (out handshake), count_o, overflow_o.
module decode_issue_queue
  import decode_issue_queue_pkg::*;
#(
  parameter int Depth        = 4,
  parameter int PtrWidth     = 2,
  parameter int PayloadWidth = PAYLOAD_WIDTH
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    flush_i,
  input  logic                    enable_i,
  input  logic [PayloadWidth-1:0] instr_i,
  output logic                    stall_o,
  output logic                    valid_o,
  output logic [PayloadWidth-1:0] instr_o,
  input  logic                    ready_i,
  output logic [PtrWidth:0]       count_o,
  output logic                    overflow_o
);

  logic [PayloadWidth-1:0] mem [Depth];
  logic [PtrWidth-1:0]     wr_idx;
  logic [PtrWidth-1:0]     rd_idx;
  logic                    full;
  logic                    empty;
  logic                    push_ok;

  sync_fifo_ptr #(
    .PtrWidth(PtrWidth)
  ) u_ptr (
    .clk    (clock_i),
    .rst    (reset_i),
    .flush  (flush_i),
    .push   (enable_i),
    .pop    (ready_i),
    .wr_idx (wr_idx),
    .rd_idx (rd_idx),
    .full   (full),
    .empty  (empty),
    .count  (count_o),
    .push_ok(push_ok)
  );

  assign stall_o = full;
  assign valid_o = !empty;
  assign instr_o = mem[rd_idx];

  // Storage is only read while valid, so it carries no reset.
  always_ff @(posedge clock_i) begin
    if (push_ok) mem[wr_idx] <= instr_i;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)                overflow_o <= 1'b0;
    else if (flush_i)           overflow_o <= 1'b0;
    else if (enable_i && full)  overflow_o <= 1'b1;
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
module tb_decode_issue_queue;
  import decode_issue_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PW    = PAYLOAD_WIDTH;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          flush_i = 1'b0;
  logic          enable_i = 1'b0;
  logic [PW-1:0] instr_i = '0;
  logic          stall_o;
  logic          valid_o;
  logic [PW-1:0] instr_o;
  logic          ready_i = 1'b0;
  logic [2:0]    count_o;
  logic          overflow_o;

  decode_issue_queue dut (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .flush_i   (flush_i),
    .enable_i  (enable_i),
    .instr_i   (instr_i),
    .stall_o   (stall_o),
    .valid_o   (valid_o),
    .instr_o   (instr_o),
    .ready_i   (ready_i),
    .count_o   (count_o),
    .overflow_o(overflow_o)
  );

  always #5 clock_i = ~clock_i;

  int errors = 0;
  int checks = 0;

  // Reference model: queue contents (also the scoreboard) and sticky flag.
  logic [PW-1:0] exp_q[$];
  int            mdl_cnt = 0;
  bit            mdl_ovf = 1'b0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: head payload must match the oldest expected entry; pop on handshake.
  always @(negedge clock_i) begin
    if (reset_i !== 1'b1 && valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL head_unexpected: got addr %h expected no entry", instr_address(instr_o));
      end else begin
        if (instr_o !== exp_q[0]) begin
          errors++;
          $display("FAIL head_payload: got %h expected %h", instr_o, exp_q[0]);
        end
        if (ready_i && !flush_i) void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic [PW-1:0] mk(input logic [63:0] addr, input logic [5:0] op,
                                       input logic [4:0] fmt, input logic [63:0] imm);
    decoded_instr_t d;
    d = '0;
    d.imm     = imm;
    d.imm_en  = 1'b1;
    d.address = addr;
    d.opcode  = op;
    d.format  = fmt;
    return d;
  endfunction

  function automatic logic [PW-1:0] rnd_payload();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  // One clock cycle: drive at posedge+1, check state at negedge, update model after edge.
  task automatic cycle(input logic en, input logic [PW-1:0] ins, input logic rdy, input logic fl);
    bit full, enq, deq;
    enable_i = en; instr_i = ins; ready_i = rdy; flush_i = fl;
    full = (mdl_cnt == DEPTH);
    enq  = en && !full && !fl;
    deq  = rdy && (mdl_cnt > 0) && !fl;
    @(negedge clock_i);
    chk("count", count_o, mdl_cnt);
    chk("valid", valid_o, mdl_cnt != 0);
    chk("stall", stall_o, full);
    chk("overflow", overflow_o, mdl_ovf);
    @(posedge clock_i);
    #1;
    if (fl) begin
      mdl_cnt = 0;
      mdl_ovf = 1'b0;
      exp_q.delete();
    end else begin
      if (en && full) mdl_ovf = 1'b1;
      mdl_cnt = mdl_cnt + (enq ? 1 : 0) - (deq ? 1 : 0);
      if (enq) exp_q.push_back(ins);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] held;
    logic          hold_en;
    reset_i = 1'b1;
    repeat (2) @(posedge clock_i);
    @(negedge clock_i);
    chk("reset_count", count_o, 0);
    chk("reset_valid", valid_o, 0);
    chk("reset_stall", stall_o, 0);
    chk("reset_overflow", overflow_o, 0);
    reset_i = 1'b0;
    @(posedge clock_i);
    #1;

    // Single instruction in and out.
    cycle(1, mk(64'h1000, 6'd14, FMT_D, 64'hFFFF_FFFF_FFFF_FFFC), 0, 0);
    cycle(0, '0, 0, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);

    // Fill, overflow attempt, ordered drain, flush clears overflow.
    for (int i = 0; i < 4; i++) cycle(1, mk(64'h1000 + 64'(4 * i), 6'd1, FMT_A, 64'(i)), 0, 0);
    cycle(1, mk(64'h2000, 6'd2, FMT_A, 64'd0), 0, 0);
    cycle(0, '0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 0);

    // Full with enable and ready together: dequeue only, held entry follows.
    for (int i = 0; i < 4; i++) cycle(1, mk(64'h3000 + 64'(4 * i), 6'd3, FMT_D, 64'd7), 0, 0);
    held = mk(64'h3010, 6'd4, FMT_Z23, 64'd9);
    cycle(1, held, 1, 0);
    cycle(1, held, 0, 0);
    cycle(0, '0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 1);

    // Streaming: ten through with count steady at one; pointers wrap.
    for (int i = 0; i < 10; i++) cycle(1, mk(64'h4000 + 64'(4 * i), 6'(i), FMT_A, 64'(i)), 1, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);

    // Flush with a concurrent enqueue drops everything.
    for (int i = 0; i < 3; i++) cycle(1, mk(64'h5000 + 64'(4 * i), 6'd5, FMT_D, 64'd1), 0, 0);
    cycle(1, mk(64'h5FFF, 6'd6, FMT_D, 64'd2), 0, 1);
    cycle(0, '0, 0, 0);

    // Asynchronous reset mid-cycle with two entries.
    cycle(1, mk(64'h6000, 6'd7, FMT_A, 64'd3), 0, 0);
    cycle(1, mk(64'h6004, 6'd7, FMT_A, 64'd4), 0, 0);
    enable_i = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    chk("async_rst_valid", valid_o, 0);
    chk("async_rst_count", count_o, 0);
    chk("async_rst_stall", stall_o, 0);
    mdl_cnt = 0; mdl_ovf = 1'b0; exp_q.delete();
    @(negedge clock_i);
    #1 reset_i = 1'b0;
    @(posedge clock_i);
    #1;
    cycle(1, mk(64'h7000, 6'd8, FMT_D, 64'd5), 0, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);

    // Random traffic; decode holds its instruction while stalled.
    hold_en = 1'b0;
    held = '0;
    for (int n = 0; n < 400; n++) begin
      logic          en, rdy, fl;
      logic [PW-1:0] ins;
      if (hold_en && mdl_cnt == DEPTH) begin
        en = 1'b1; ins = held;
      end else begin
        en = ($urandom_range(0, 3) != 0); ins = rnd_payload();
      end
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 29) == 0);
      held = ins; hold_en = en;
      cycle(en, ins, rdy, fl);
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, '0, 1, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
